// File: rtl/cwe_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cwe_cfg_pkg                                               |
// | Brief    : Shared constants and FSM encoding for the config writer.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cwe_cfg_pkg;

  localparam int C_ADDR_W = 2;
  localparam int C_ERR_W  = 8;

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_CHECK  = 2'd1;
  localparam logic [1:0] C_ST_COMMIT = 2'd2;
  localparam logic [1:0] C_ST_REJECT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_CHECK  = C_ST_CHECK,
    ST_COMMIT = C_ST_COMMIT,
    ST_REJECT = C_ST_REJECT
  } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/cwe_cfg_chan_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cwe_cfg_chan_reg                                          |
// | Brief    : One channel data word plus its sticky lock bit.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cwe_cfg_chan_reg #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  set_lock,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  locked
);

  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= RESET_VAL;
      r_locked <= 1'b0;
    end else begin
      if (we) r_q <= d;
      // Lock is sticky: only reset clears it.
      if (we && set_lock) r_locked <= 1'b1;
    end
  end

  assign q      = r_q;
  assign locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/cwe1271_cfg_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cwe1271_cfg_writer                                        |
// | Brief    : Reset-safe config write sequencer with per-channel locks. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cwe1271_cfg_writer
  import cwe_cfg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_CH     = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [C_ADDR_W-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]        req_data,
  input  logic                         req_lock,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_we,
  output logic [NUM_CH-1:0]            ch_locked,
  output logic                         resp_valid,
  output logic                         resp_err,
  output logic [C_ERR_W-1:0]           err_count
);

  localparam logic [C_ADDR_W:0] C_NUM_CH = (C_ADDR_W+1)'(NUM_CH);

  cfg_state_e            r_state, w_state_nxt;
  logic [C_ADDR_W-1:0]   r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_lock;
  logic [NUM_CH-1:0]     w_we, w_set_lock, r_ch_we;
  logic [3:0]            w_lock_pad;
  logic                  w_reject;
  logic                  r_resp_valid, r_resp_err;
  logic [C_ERR_W-1:0]    r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = w_reject ? ST_REJECT : ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      ST_REJECT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_lock <= 1'b0;
    end else if (req_valid && req_ready) begin
      r_addr <= req_addr;
      r_data <= req_data;
      r_lock <= req_lock;
    end
  end

  // Pad lock bits to the full address space so out-of-range indices read as locked-safe.
  always_comb begin
    w_lock_pad = '0;
    w_we       = '0;
    w_set_lock = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_lock_pad[i] = ch_locked[i];
      if (r_state == ST_COMMIT && r_addr == C_ADDR_W'(i)) begin
        w_we[i]       = 1'b1;
        w_set_lock[i] = r_lock;
      end
    end
  end

  assign w_reject = ({1'b0, r_addr} >= C_NUM_CH) || w_lock_pad[r_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_we      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_ch_we      <= w_we;
      r_resp_valid <= (r_state == ST_COMMIT) || (r_state == ST_REJECT);
      r_resp_err   <= (r_state == ST_REJECT);
      if (r_state == ST_REJECT && r_err_count != {C_ERR_W{1'b1}})
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign ch_we      = r_ch_we;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign err_count  = r_err_count;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    cwe_cfg_chan_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  (RESET_VAL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .we       (w_we[g]),
      .set_lock (w_set_lock[g]),
      .d        (r_data),
      .q        (ch_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .locked   (ch_locked[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/cwe1271_cfg_writer.md
# cwe1271_cfg_writer

Reset-safe configuration write sequencer. It sits directly upstream of the per-channel capture registers and drives their data and write-enable inputs. Every output has a defined value from reset. Writes arrive on a valid/ready request port, are checked against per-channel sticky lock bits, and either commit to the channel with a one-cycle write strobe or are rejected and counted.

## Interface
- `DATA_WIDTH`, default 8: width of each channel's data word.
- `NUM_CH`, default 3: number of channels. Legal range 1..4.
- `RESET_VAL`, default 0: value every channel data word takes on reset.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: a write request is presented.
- `req_ready`  out  1: the block can accept a request.
- `req_addr`  in  2: target channel index.
- `req_data`  in  DATA_WIDTH: write data.
- `req_lock`  in  1: set the channel's lock bit when this write commits.
- `ch_data`  out  NUM_CH*DATA_WIDTH: registered channel words. Channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ch_we`  out  NUM_CH: one-cycle write strobe per channel.
- `ch_locked`  out  NUM_CH: current lock bits.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_err`  out  1: qualifies `resp_valid`. 1 means the write was rejected.
- `err_count`  out  8: count of rejected writes, saturating at 255.

## Operation
- FSM states: IDLE, CHECK, COMMIT, REJECT.
- **IDLE:**
  - `req_ready`=1.
  - When `req_valid`&&`req_ready`, latch addr, data and lock into holding registers, then go to CHECK.
- **CHECK:**
  - `req_ready`=0.
  - If addr>=NUM_CH or lock[addr]=1, go to REJECT. Otherwise go to COMMIT.
- **COMMIT:**
  - Write the held data into channel addr and assert `ch_we[addr]`=1 for this cycle.
  - If the held lock flag is 1, set lock[addr].
  - `resp_valid`=1, `resp_err`=0.
  - Go to IDLE.
- **REJECT:**
  - `resp_valid`=1, `resp_err`=1.
  - `err_count` += 1, saturating at 255.
  - No channel data, lock bit or `ch_we` changes.
  - Go to IDLE.
- Lock bits are sticky and cleared only by `rst`. A write with `req_lock`=1 to an already-locked channel is rejected.
- `ch_we` is one-hot or zero. It is never asserted outside COMMIT.
- Request inputs are sampled only on the accept edge. Changes on `req_addr`/`req_data` while `req_ready`=0 have no effect.

## Timing
- Reset values:
  - State = IDLE.
  - Every channel word = RESET_VAL.
  - Lock bits = 0, `err_count` = 0.
  - `ch_we`, `resp_valid`, `resp_err` = 0.
  - `req_ready` = 1 as soon as `rst` deasserts.
- Latency: a request accepted on edge N produces `ch_data` update, `ch_we` and `resp_valid` visible after edge N+2. The channel word and strobe are coincident.
- Throughput: one request per 3 cycles. `req_ready` is low for the two cycles after an accept.
- `rst` asserted mid-transaction: the held request is dropped, no response is issued, and all state returns to reset values immediately (asynchronous).
- `err_count` at 255 stays at 255 on further rejects. `resp_err` still pulses.
- `ch_data`, `ch_locked`, `err_count`, `resp_*` and `ch_we` are all registered outputs. None is combinational from the inputs.

## Structure
- The shared package `cwe_cfg_pkg` holds:
  - FSM state encodings as localparams (2-bit).
  - Address width constant (2).
  - Error counter width (8).
- Sub-module `cwe_cfg_chan_reg`: one channel word plus lock bit with async reset to RESET_VAL/0 and inputs `we` and `set_lock`. It is instantiated NUM_CH times via generate.
- The top level holds the FSM, holding registers, address decode and error counter.

## Test plan
- Reset release with no requests: every `ch_data` word = 0x00, `ch_locked`=000, `err_count`=0, `req_ready`=1.
- Write addr=1, data=0xA5, lock=0: two cycles after accept, `ch_data[15:8]`=0xA5, `ch_we`=010 for one cycle, `resp_valid`=1 with `resp_err`=0. Other channels stay 0x00.
- Write addr=2, data=0x3C, lock=1, then addr=2, data=0xFF: first write commits and `ch_locked`=100. Second gets `resp_err`=1, `ch_data[23:16]` stays 0x3C, `err_count`=1.
- Write addr=3 with NUM_CH=3: rejected, `ch_we`=000, `err_count` increments. Then 300 rejected writes in total: `err_count` holds at 255.
- Assert `rst` in the cycle after accepting addr=0, data=0x55: no `resp_valid`, no `ch_we`, `ch_data[7:0]`=0x00, and lock bits cleared, including previously locked channels.
- Hold `req_valid`=1 with data changing every cycle: only the values present on each accept edge commit, one commit every 3 cycles.
